range_session_sched: RTL and testbench
======================================

Name: range_session_sched

Overview:
- Round-robin scheduler that shares one min/max range-measurement datapath between NUM_REQ sample streams.
- Grants one requester per session and drives the datapath's go/data/finish interface for exactly the configured number of valid samples.
- Captures the datapath's combinational range output and returns it, tagged with the requester ID.
- Sits between the per-channel sample sources and the shared range unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 10, sample and range width
- CNT_W, 8, width of session length and sample counter
- TIMEOUT, 64, idle-sample timeout in cycles (used only with the optional feature)

Ports:
- clock  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- req  input  NUM_REQ  per-requester session request (level)
- samp_data  input  NUM_REQ*DATA_W  packed sample buses; requester i uses [i*DATA_W +: DATA_W]
- samp_valid  input  NUM_REQ  per-requester sample valid
- cfg_len  input  CNT_W  samples per session, sampled at grant
- grant  output  NUM_REQ  one-hot, held for the whole session
- rf_data  output  DATA_W  sample to the range unit
- rf_go  output  1  session start strobe to the range unit
- rf_finish  output  1  session end strobe to the range unit
- rf_range  input  DATA_W  range unit result (high minus low), combinational
- result_data  output  DATA_W  captured range
- result_id  output  $clog2(NUM_REQ)  requester that owns result_data
- result_valid  output  1  one-cycle result strobe
- busy  output  1  high in any state other than IDLE
- timeout_err  output  1  one-cycle abort strobe (optional feature only, else tied 0)

Behaviour:
- Reset: state=IDLE; grant=0, rf_go=0, rf_finish=0, rf_data=0, result_data=0, result_id=0, result_valid=0, busy=0, timeout_err=0, rr_ptr=0, hold=0, count=0.
- FSM states: IDLE, FIRST, RUN, CAPTURE.
- IDLE:
  - If req is non-zero, select the first set bit searching upward from rr_ptr, wrapping at NUM_REQ.
  - Register the winner's ID, latch len = max(cfg_len, 2), set grant one-hot, set rr_ptr = winner+1 mod NUM_REQ, go to FIRST.
  - With no request, stay in IDLE; rf_data=0.
  - Grant appears the cycle after req is seen.
- FIRST:
  - Wait for samp_valid[id]. On a valid sample: rf_go=1, rf_data=sample, hold<=sample, count<=1, go to RUN.
  - With no valid sample: rf_go=0, rf_data=0.
- RUN:
  - rf_data = samp_valid[id] ? sample : hold, so an invalid cycle replays the last sample and leaves min/max unchanged.
  - On each valid sample: hold<=sample, count<=count+1.
  - The valid sample taking count to len asserts rf_finish=1 in that same cycle, then the FSM goes to CAPTURE.
- CAPTURE (one cycle):
  - result_data<=rf_range, result_id<=id, result_valid=1 for exactly one cycle, grant<=0, go to IDLE.
  - result_valid therefore rises the cycle after rf_finish.
- rf_go and rf_finish are never asserted in the same cycle. rf_go is asserted exactly once per session; rf_finish at most once.
- req is sampled only in IDLE. Dropping req mid-session is ignored and the session completes.
- Samples and valids from non-granted requesters are ignored.
- cfg_len of 0 or 1 is treated as 2. cfg_len changes mid-session are ignored.
- Back-to-back sessions: minimum gap is IDLE (1 cycle) between CAPTURE and the next FIRST.
- Reset mid-session: all outputs return to reset values asynchronously; no result is produced; rr_ptr=0.
- Range arithmetic is owned by the range unit; this block passes rf_range through unmodified, with width DATA_W.

Optional Feature:
- Macro: RANGE_SCHED_TIMEOUT_EN.
- Defined:
  - A counter tracks consecutive cycles without samp_valid[id] in FIRST or RUN.
  - When it reaches TIMEOUT: in RUN, assert rf_finish with rf_data=hold; in FIRST, assert nothing to the range unit.
  - Then pulse timeout_err=1 for one cycle, drop grant, return to IDLE, with no result_valid.
  - The counter clears on every valid sample and on grant.
- Undefined: no counter is present, timeout_err is tied 0, and a session waits indefinitely.

Test Plan:
- Single requester:
  - Stimulus: req=0001, cfg_len=4, samples 5,9,2,7 on consecutive cycles, rf_range model = max-min.
  - Required: rf_go on sample 5, rf_finish on sample 7, result_data=7, result_id=0, result_valid one cycle after finish.
- Gapped valid:
  - Stimulus: req=0100, cfg_len=3, samples 3,(invalid x2),8,1.
  - Required: rf_data replays 3 during the gaps, finish on 1, result_data=7, result_id=2.
- Round-robin:
  - Stimulus: req=1111 held with cfg_len=2.
  - Required: grant order 0001,0010,0100,1000,0001; no two grants overlap; one result per session.
- Length clamp:
  - Stimulus: cfg_len=0, samples 4,4.
  - Required: session ends after 2 valid samples; result_data=0; rf_go and rf_finish in different cycles.
- Reset mid-session:
  - Stimulus: assert reset in RUN after 2 of 4 samples.
  - Required: grant=0 and busy=0 immediately; no result_valid; next session after reset starts with requester 0 priority.
- With RANGE_SCHED_TIMEOUT_EN, TIMEOUT=64:
  - Stimulus: grant, then 1 valid sample, then silence.
  - Required: rf_finish and timeout_err pulse 64 cycles after the last valid sample; no result_valid; return to IDLE.

Source files
------------

// File: rtl/range_session_sched.sv
// Round-robin scheduler sharing one min/max range unit between NUM_REQ sample streams.
// Optional idle-sample timeout abort is enabled by defining RANGE_SCHED_TIMEOUT_EN.
module range_session_sched #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 10,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ*DATA_W-1:0]  samp_data,
  input  logic [NUM_REQ-1:0]         samp_valid,
  input  logic [CNT_W-1:0]           cfg_len,
  output logic [NUM_REQ-1:0]         grant,
  output logic [DATA_W-1:0]          rf_data,
  output logic                       rf_go,
  output logic                       rf_finish,
  input  logic [DATA_W-1:0]          rf_range,
  output logic [DATA_W-1:0]          result_data,
  output logic [$clog2(NUM_REQ)-1:0] result_id,
  output logic                       result_valid,
  output logic                       busy,
  output logic                       timeout_err
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FIRST   = 2'd1,
    RUN     = 2'd2,
    CAPTURE = 2'd3
  } state_t;

  state_t            state, state_next;
  logic [IDW-1:0]    id, rr_ptr, pick_id, rr_next;
  logic              pick_found;
  logic [CNT_W-1:0]  len, count, len_clamped;
  logic [DATA_W-1:0] hold, result_hold, sample;
  logic [DATA_W-1:0] lane [NUM_REQ];
  logic              sample_valid, last_sample, timeout_hit;
  int                probe;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDW-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign lane[i] = samp_data[i*DATA_W +: DATA_W];
  end

  assign sample       = lane[id];
  assign sample_valid = samp_valid[id];
  assign len_clamped  = (cfg_len < CNT_W'(2)) ? CNT_W'(2) : cfg_len;
  assign last_sample  = (state == RUN) && sample_valid && (count == len - CNT_W'(1));

  // Round-robin pick: scan downward so the lowest offset from rr_ptr wins
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    probe      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      probe      = (int'(rr_ptr) + k) % NUM_REQ;
      pick_id    = req[probe] ? IDW'(probe) : pick_id;
      pick_found = pick_found | req[probe];
    end
    rr_next = IDW'((int'(pick_id) + 1) % NUM_REQ);
  end

`ifdef RANGE_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] idle_cnt;

  assign timeout_hit = ((state == FIRST) || (state == RUN)) && !sample_valid &&
                       (idle_cnt == TW'(TIMEOUT - 1));

  // Consecutive cycles without a valid sample from the granted requester
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (((state == FIRST) || (state == RUN)) && !sample_valid) begin
      idle_cnt <= idle_cnt + TW'(1);
    end else begin
      idle_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and range-unit strobes
  always_comb begin
    state_next   = state;
    rf_go        = 1'b0;
    rf_finish    = 1'b0;
    rf_data      = '0;
    result_valid = 1'b0;
    result_data  = result_hold;
    busy         = (state != IDLE);
    timeout_err  = timeout_hit;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_next = FIRST;
        end else begin
          state_next = IDLE;
        end
      end
      FIRST: begin
        if (sample_valid) begin
          rf_go      = 1'b1;
          rf_data    = sample;
          state_next = RUN;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end else begin
          state_next = FIRST;
        end
      end
      RUN: begin
        // Replaying the held sample on a gap leaves the unit's min/max untouched
        rf_data = sample_valid ? sample : hold;
        if (last_sample) begin
          rf_finish  = 1'b1;
          state_next = CAPTURE;
        end else if (timeout_hit) begin
          rf_finish  = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = RUN;
        end
      end
      CAPTURE: begin
        result_valid = 1'b1;
        result_data  = rf_range;
        state_next   = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Session bookkeeping: grant, requester ID, length, sample count and held sample
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id          <= '0;
      rr_ptr      <= '0;
      len         <= '0;
      count       <= '0;
      hold        <= '0;
      grant       <= '0;
      result_hold <= '0;
      result_id   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            id     <= pick_id;
            len    <= len_clamped;
            grant  <= onehot(pick_id);
            rr_ptr <= rr_next;
            count  <= '0;
          end
        end
        FIRST, RUN: begin
          if (sample_valid) begin
            hold  <= sample;
            count <= count + CNT_W'(1);
          end else if (timeout_hit) begin
            grant <= '0;
          end
          if (last_sample) begin
            result_id <= id;
          end
        end
        CAPTURE: begin
          result_hold <= rf_range;
          grant       <= '0;
        end
        default: begin
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_range_session_sched.sv
// Self-checking bench for range_session_sched: directed scenarios plus random traffic
// checked against a session-level reference model and a behavioural range unit.
module tb_range_session_sched;
  localparam int N   = 4;
  localparam int DW  = 10;
  localparam int CW  = 8;
  localparam int IDW = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [N-1:0]  req, samp_valid, grant;
  logic [N*DW-1:0] samp_data;
  logic [CW-1:0] cfg_len;
  logic [DW-1:0] rf_data, rf_range, result_data;
  logic          rf_go, rf_finish, result_valid, busy, timeout_err;
  logic [IDW-1:0] result_id;

  always #5 clock = ~clock;

  range_session_sched #(.NUM_REQ(N), .DATA_W(DW), .CNT_W(CW), .TIMEOUT(64)) dut (
    .clock(clock), .reset(reset), .req(req), .samp_data(samp_data),
    .samp_valid(samp_valid), .cfg_len(cfg_len), .grant(grant), .rf_data(rf_data),
    .rf_go(rf_go), .rf_finish(rf_finish), .rf_range(rf_range),
    .result_data(result_data), .result_id(result_id), .result_valid(result_valid),
    .busy(busy), .timeout_err(timeout_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int span(input int q[$]);
    int mx, mn;
    if (q.size() == 0) return 0;
    mx = q[0];
    mn = q[0];
    foreach (q[i]) begin
      if (q[i] > mx) mx = q[i];
      if (q[i] < mn) mn = q[i];
    end
    return mx - mn;
  endfunction

  // Behavioural range unit: remembers every value it was fed since go
  int          rng_q[$];
  bit          rng_active;
  bit          cap_go, cap_fin;
  int          cap_data;

  task automatic range_update();
    if (cap_go) begin
      rng_q.delete();
      rng_q.push_back(cap_data);
      rng_active = 1'b1;
    end else if (rng_active) begin
      rng_q.push_back(cap_data);
    end
    if (cap_fin) rng_active = 1'b0;
    rf_range = DW'(span(rng_q));
  endtask

  // Session-level reference model
  bit m_sess, m_done;
  int m_id, m_len, m_rr, m_got;
  int m_samp[$];
  int cyc_no, go_cyc, fin_cyc, res_count, last_res_id;
  int last_res_data;

  task automatic model_reset();
    m_sess = 1'b0; m_done = 1'b0; m_rr = 0; m_got = 0; m_id = 0; m_len = 0;
    m_samp.delete();
    rng_q.delete(); rng_active = 1'b0; rf_range = '0;
    cap_go = 1'b0; cap_fin = 1'b0; cap_data = 0;
  endtask

  task automatic model_cycle();
    logic [N-1:0] eg;
    bit v, found;
    int s, p;
    cyc_no++;
    eg = '0;
    if (m_sess) eg[m_id] = 1'b1;
    check("grant", grant, eg);
    check("busy", busy, m_sess);
    check("timeout_err", timeout_err, 0);
    check("result_valid", result_valid, m_done);
    cap_go = rf_go; cap_fin = rf_finish; cap_data = rf_data;
    if (rf_go) go_cyc = cyc_no;
    if (rf_finish) fin_cyc = cyc_no;
    if (result_valid) begin
      res_count++;
      last_res_data = result_data;
      last_res_id   = result_id;
    end
    if (m_sess && !m_done) begin
      v = samp_valid[m_id];
      s = samp_data[m_id*DW +: DW];
      check("rf_go", rf_go, v && (m_got == 0));
      check("rf_finish", rf_finish, v && (m_got + 1 == m_len));
      check("rf_data", rf_data, v ? s : ((m_got == 0) ? 0 : m_samp[$]));
      if (v) begin
        m_samp.push_back(s);
        m_got++;
        if (m_got == m_len) m_done = 1'b1;
      end
    end else if (m_done) begin
      check("cap_go", rf_go, 0);
      check("cap_finish", rf_finish, 0);
      check("result_data", result_data, span(m_samp));
      check("result_id", result_id, m_id);
      m_sess = 1'b0;
      m_done = 1'b0;
    end else begin
      check("idle_go", rf_go, 0);
      check("idle_finish", rf_finish, 0);
      check("idle_data", rf_data, 0);
      if (req != '0) begin
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
          p = (m_rr + k) % N;
          if (!found && req[p]) begin
            found = 1'b1;
            m_id  = p;
          end
        end
        m_len  = (cfg_len < 2) ? 2 : int'(cfg_len);
        m_rr   = (m_id + 1) % N;
        m_sess = 1'b1;
        m_got  = 0;
        m_samp.delete();
      end
    end
  endtask

  // One clock: update range unit, drive inputs, check at the falling edge
  task automatic step(input logic [N-1:0] r, input logic [N-1:0] vm, input int d, input int cfg);
    @(posedge clock);
    #1;
    range_update();
    req        = r;
    samp_valid = vm;
    cfg_len    = CW'(cfg);
    for (int i = 0; i < N; i++) samp_data[i*DW +: DW] = (d < 0) ? DW'($urandom) : DW'(d);
    @(negedge clock);
    if (!reset) model_cycle();
  endtask

  logic [N-1:0] gseq [8];
  logic [N-1:0] prev_g;
  int gcount, res_base;

  initial begin
    reset = 1'b1; req = '0; samp_valid = '0; samp_data = '0; cfg_len = '0;
    cyc_no = 0; go_cyc = 0; fin_cyc = 0; res_count = 0; last_res_id = 0; last_res_data = 0;
    model_reset();
    #2;
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_rvalid", result_valid, 0);
    check("rst_rdata", result_data, 0);
    check("rst_rid", result_id, 0);
    check("rst_go", rf_go, 0);
    check("rst_finish", rf_finish, 0);
    check("rst_rfdata", rf_data, 0);
    check("rst_timeout", timeout_err, 0);
    #10 reset = 1'b0;

    // Single requester: 5,9,2,7
    step(4'b0001, 4'b0000, 0, 4);
    step(4'b0000, 4'b0001, 5, 4);
    step(4'b0000, 4'b0001, 9, 4);
    step(4'b0000, 4'b0001, 2, 4);
    step(4'b0000, 4'b0001, 7, 4);
    step(4'b0000, 4'b0000, 0, 4);
    check("t1_result", last_res_data, 7);
    check("t1_id", last_res_id, 0);
    check("t1_go_to_fin", fin_cyc - go_cyc, 3);
    step(4'b0000, 4'b0000, 0, 4);

    // Gapped valid on requester 2: 3, gap, gap, 8, 1
    step(4'b0100, 4'b0000, 0, 3);
    step(4'b0000, 4'b0100, 3, 3);
    step(4'b0000, 4'b0000, 0, 3);
    step(4'b0000, 4'b0000, 0, 3);
    step(4'b0000, 4'b0100, 8, 3);
    step(4'b0000, 4'b0100, 1, 3);
    step(4'b0000, 4'b0000, 0, 3);
    check("t2_result", last_res_data, 7);
    check("t2_id", last_res_id, 2);
    step(4'b0000, 4'b0000, 0, 3);

    // Reset in RUN after 2 of 4 samples
    res_base = res_count;
    step(4'b0100, 4'b0000, 0, 4);
    step(4'b0000, 4'b0100, 1, 4);
    step(4'b0000, 4'b0100, 2, 4);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_grant", grant, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rvalid", result_valid, 0);
    model_reset();
    step(4'b0000, 4'b0000, 0, 4);
    step(4'b0000, 4'b0000, 0, 4);
    #2 reset = 1'b0;
    check("mid_rst_no_result", res_count, res_base);

    // Round-robin with all requesters held, cfg_len = 2
    res_base = res_count;
    gcount = 0;
    prev_g = '0;
    foreach (gseq[i]) gseq[i] = '0;
    for (int c = 0; c < 20; c++) begin
      step(4'b1111, 4'b1111, -1, 2);
      check("rr_onehot", $onehot0(grant), 1);
      if (grant != '0 && prev_g == '0 && gcount < 8) begin
        gseq[gcount] = grant;
        gcount++;
      end
      prev_g = grant;
    end
    for (int c = 0; c < 4; c++) step(4'b0000, 4'b1111, -1, 2);
    check("rr_g0", gseq[0], 4'b0001);
    check("rr_g1", gseq[1], 4'b0010);
    check("rr_g2", gseq[2], 4'b0100);
    check("rr_g3", gseq[3], 4'b1000);
    check("rr_g4", gseq[4], 4'b0001);
    check("rr_results", res_count - res_base, 5);

    // Length clamp: cfg_len = 0, samples 4,4
    res_base = res_count;
    step(4'b0010, 4'b0000, 0, 0);
    step(4'b0000, 4'b0010, 4, 0);
    step(4'b0000, 4'b0010, 4, 0);
    step(4'b0000, 4'b0000, 0, 0);
    check("clamp_result", last_res_data, 0);
    check("clamp_count", res_count - res_base, 1);
    check("clamp_sep", fin_cyc, go_cyc + 1);
    step(4'b0000, 4'b0000, 0, 0);

    // Random traffic
    for (int c = 0; c < 1500; c++) begin
      step(N'($urandom_range(0, 15)), N'($urandom), -1, $urandom_range(0, 6));
    end
    for (int c = 0; c < 40; c++) step(4'b0000, 4'b1111, -1, 2);
    check("final_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
